conv_9_11_mul_arb: RTL and testbench
====================================

CONV_9_11_MUL_ARB -- requirements
Module: conv_9_11_mul_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter DIN0_WIDTH, default 16, signed operand-A width.
REQ-003 SHALL have parameter DIN1_WIDTH, default 8, signed operand-B width.
REQ-004 SHALL have parameter DOUT_WIDTH, default 24, signed product width (DIN0_WIDTH+DIN1_WIDTH).
REQ-005 SHALL have port ap_clk  input  1  the single clock; all state on rising edge.
REQ-006 SHALL have port ap_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester operand valid.
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester accept.
REQ-009 SHALL have port req_din0  input  NUM_REQ*DIN0_WIDTH  packed operand A, requester i at bits [i*DIN0_WIDTH +: DIN0_WIDTH].
REQ-010 SHALL have port req_din1  input  NUM_REQ*DIN1_WIDTH  packed operand B, same packing.
REQ-011 SHALL have port rsp_valid  output  1  product valid.
REQ-012 SHALL have port rsp_ready  input  1  downstream accept.
REQ-013 SHALL have port rsp_dout  output  DOUT_WIDTH  signed product.
REQ-014 SHALL have port rsp_id  output  clog2(NUM_REQ)  index of requester owning rsp_dout.
REQ-015 SHALL have port op_count  output  32  number of completed accepts on req side, wrapping.

Function
REQ-016 SHALL grant at most one requester per cycle, round-robin: search starts at rr_ptr, first asserted req_valid wins.
REQ-017 SHALL compute can_issue = !rsp_valid || rsp_ready (output register free or draining this cycle).
REQ-018 SHALL drive req_ready[i] = grant[i] && can_issue; all other req_ready bits 0; req_ready combinational, never depends on rsp_ready of another cycle.
REQ-019 SHALL, on accept (req_valid[g] && req_ready[g]), register signed(din0[g]) * signed(din1[g]) into rsp_dout, g into rsp_id, set rsp_valid=1; latency exactly 1 cycle.
REQ-020 SHALL form product at full precision, two's complement, no truncation or saturation (-32768 * -128 = 4194304).
REQ-021 SHALL set rr_ptr to (g+1) mod NUM_REQ after each accept; rr_ptr unchanged on cycles without accept.
REQ-022 SHALL hold rsp_dout, rsp_id, rsp_valid stable while rsp_valid && !rsp_ready.
REQ-023 SHALL clear rsp_valid when rsp_valid && rsp_ready and no accept occurs that cycle.
REQ-024 SHALL, on simultaneous drain and accept, load the new product with rsp_valid staying 1 (back-to-back throughput 1/cycle).
REQ-025 SHALL ignore req_din0/req_din1 of non-granted requesters.
REQ-026 SHALL increment op_count by 1 per accept; 0xFFFFFFFF wraps to 0.
REQ-027 SHALL guarantee no starvation: a requester holding req_valid is accepted within NUM_REQ accepts.

Reset
REQ-028 SHALL, while ap_rst_n=0, force rsp_valid=0, rsp_dout=0, rsp_id=0, rr_ptr=0, op_count=0, asynchronously.
REQ-029 SHALL drive req_ready all-zero during reset.
REQ-030 SHALL discard any in-flight product on reset mid-operation; first accept after release is from lowest-index valid requester.

Structure
REQ-031 SHALL place default widths, NUM_REQ default and ID-width function (clog2) in shared package conv_9_11_pkg.
REQ-032 SHALL instantiate exactly one conv_9_11_mul_mulbkb (combinational, NUM_STAGE=1) as the product datapath; arbiter, pointer, output register and counter in this module.
REQ-033 SHALL contain no latches; grant logic purely combinational from req_valid and rr_ptr.

Verification
REQ-034 SHALL test: reset release, only req 2 valid with din0=0x0003, din1=0xFE -> next cycle rsp_valid=1, rsp_dout=-6 (0xFFFFFA), rsp_id=2, op_count=1.
REQ-035 SHALL test: all 4 valid continuously, rsp_ready=1 -> accepts in order 0,1,2,3,0,... one per cycle, op_count+1 each cycle.
REQ-036 SHALL test: rsp_ready=0 for 5 cycles with rsp_valid=1 -> rsp_dout/rsp_id stable, all req_ready=0, op_count unchanged.
REQ-037 SHALL test: extremes din0=0x8000, din1=0x80 -> rsp_dout=0x400000; din0=0x7FFF, din1=0x80 -> 0xC00080.
REQ-038 SHALL test: ap_rst_n pulsed low mid-burst with rsp_valid=1 -> rsp_valid=0 immediately, op_count=0, rr_ptr restarts at 0.
REQ-039 SHALL test: op_count preloaded near wrap via 2^32 accepts or forced value 0xFFFFFFFF -> one accept yields 0.

Source files
------------

// File: rtl/conv_9_11_pkg.sv
// Shared defaults and helpers for the conv_9_11 multiplier arbiter slice.
package conv_9_11_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DIN0_W_DEF  = 16;
  localparam int DIN1_W_DEF  = 8;
  localparam int DOUT_W_DEF  = DIN0_W_DEF + DIN1_W_DEF;

  // Requester index width; a 2-way arbiter still needs one id bit.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_9_11_mul_mulbkb.sv
// Signed full-precision multiplier datapath (single-stage, purely combinational).
module conv_9_11_mul_mulbkb #(
  parameter int NUM_STAGE  = 1,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 24
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  // Only the combinational flavour exists; the output register lives in the arbiter.
  if (NUM_STAGE != 1) begin : g_stage_chk
    $error("conv_9_11_mul_mulbkb supports NUM_STAGE=1 only");
  end

  logic signed [dout_WIDTH-1:0] a_ext, b_ext;

  // Sign-extend both operands to the product width so the multiply is exact.
  assign a_ext = dout_WIDTH'($signed(din0));
  assign b_ext = dout_WIDTH'($signed(din1));
  assign dout  = a_ext * b_ext;

endmodule

// File: rtl/conv_9_11_mul_arb.sv
// Round-robin arbiter sharing one signed multiplier among NUM_REQ requesters,
// with a single skid-free output register and an accept counter.
module conv_9_11_mul_arb
  import conv_9_11_pkg::*;
#(
  parameter  int NUM_REQ    = NUM_REQ_DEF,
  parameter  int DIN0_WIDTH = DIN0_W_DEF,
  parameter  int DIN1_WIDTH = DIN1_W_DEF,
  parameter  int DOUT_WIDTH = DIN0_WIDTH + DIN1_WIDTH,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DOUT_WIDTH-1:0]         rsp_dout,
  output logic [ID_W-1:0]               rsp_id,
  output logic [31:0]                   op_count
);

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       gidx;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       rr_next;
  logic                  can_issue;
  logic                  accept;
  logic [DIN0_WIDTH-1:0] din0_sel;
  logic [DIN1_WIDTH-1:0] din1_sel;
  logic [DOUT_WIDTH-1:0] prod;

  // Rotating priority search: first valid requester at or after rr_ptr wins.
  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end

  // Issue only when the output slot is empty or being drained this cycle;
  // ready is held low during reset even though the slot looks free then.
  assign can_issue = !rsp_valid || rsp_ready;
  assign req_ready = ap_rst_n ? (grant & {NUM_REQ{can_issue}}) : '0;
  assign accept    = |req_ready;
  assign rr_next   = ID_W'((int'(gidx) + 1) % NUM_REQ);

  assign din0_sel = req_din0[int'(gidx)*DIN0_WIDTH +: DIN0_WIDTH];
  assign din1_sel = req_din1[int'(gidx)*DIN1_WIDTH +: DIN1_WIDTH];

  conv_9_11_mul_mulbkb #(
    .NUM_STAGE  (1),
    .din0_WIDTH (DIN0_WIDTH),
    .din1_WIDTH (DIN1_WIDTH),
    .dout_WIDTH (DOUT_WIDTH)
  ) u_mul (
    .din0 (din0_sel),
    .din1 (din1_sel),
    .dout (prod)
  );

  // Output register, round-robin pointer and accept counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rsp_valid <= 1'b0;
      rsp_dout  <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
      op_count  <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_dout  <= prod;
      rsp_id    <= gidx;
      rr_ptr    <= rr_next;
      op_count  <= op_count + 32'd1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_9_11_mul_arb.sv
// Randomized self-checking bench for conv_9_11_mul_arb against a behavioural model.
module tb_conv_9_11_mul_arb;

  localparam int N  = 4;
  localparam int W0 = 16;
  localparam int W1 = 8;
  localparam int WO = 24;

  logic            ap_clk;
  logic            ap_rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W0-1:0] req_din0;
  logic [N*W1-1:0] req_din1;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [WO-1:0]   rsp_dout;
  logic [1:0]      rsp_id;
  logic [31:0]     op_count;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic          m_valid;
  logic [WO-1:0] m_dout;
  int            m_id;
  int            m_ptr;
  logic [31:0]   m_cnt;

  conv_9_11_mul_arb #(
    .NUM_REQ    (N),
    .DIN0_WIDTH (W0),
    .DIN1_WIDTH (W1),
    .DOUT_WIDTH (WO)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dout  (rsp_dout),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Winner of a rotating search starting at ptr, -1 if nobody is asking.
  function automatic int find_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] r;
    g = find_grant(req_valid, m_ptr);
    r = '0;
    if (g >= 0 && (!m_valid || rsp_ready)) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_dout = '0; m_id = 0; m_ptr = 0; m_cnt = '0;
  endtask

  task automatic rand_data();
    req_din0 = {$urandom, $urandom};
    req_din1 = $urandom;
  endtask

  // Advance one clock; model follows the arbitration/handshake rules.
  task automatic tick();
    int g, a, b;
    logic acc;
    g   = find_grant(req_valid, m_ptr);
    acc = (g >= 0) && (!m_valid || rsp_ready);
    a = 0; b = 0;
    if (acc) begin
      a = int'($signed(req_din0[g*W0 +: W0]));
      b = int'($signed(req_din1[g*W1 +: W1]));
    end
    @(posedge ap_clk);
    if (acc) begin
      m_valid = 1'b1;
      m_dout  = WO'(a * b);
      m_id    = g;
      m_ptr   = (g + 1) % N;
      m_cnt   = m_cnt + 32'd1;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    req_din0 = '0; req_din1 = '0;
    model_reset();
    repeat (2) @(posedge ap_clk);
    #1;
    req_valid = '1;
    #1;
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_dout !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=0", rsp_dout); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
    checks++; if (op_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", op_count); end
    req_valid = '0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic test_single();
    req_valid = 4'b0100; rsp_ready = 1'b1;
    rand_data();
    req_din0[2*W0 +: W0] = 16'h0003;
    req_din1[2*W1 +: W1] = 8'hFE;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_dout !== 24'hFFFFFA) begin failures++; $display("FAIL single_dout got=%h exp=fffffa", rsp_dout); end
    checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", rsp_id); end
    checks++; if (op_count !== 32'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", op_count); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    // restart so the rotation begins at requester 0
    ap_rst_n = 1'b0; model_reset();
    @(negedge ap_clk); ap_rst_n = 1'b1;
    req_valid = '1; rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rand_data();
      #1;
      checks++; if (req_ready !== exp_ready()) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", k, req_ready, exp_ready()); end
      tick();
      checks++; if (rsp_id !== 2'(k % N)) begin failures++; $display("FAIL b2b_order cyc=%0d got=%0d exp=%0d", k, rsp_id, k % N); end
      checks++; if (rsp_dout !== m_dout || rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_dout cyc=%0d got=%h/%b exp=%h/1", k, rsp_dout, rsp_valid, m_dout); end
      checks++; if (op_count !== 32'(k + 1)) begin failures++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", k, op_count, k + 1); end
    end
  endtask

  task automatic test_backpressure();
    logic [WO-1:0] d0;
    logic [1:0]    i0;
    logic [31:0]   c0;
    req_valid = '1; rsp_ready = 1'b1; rand_data();
    tick();
    rsp_ready = 1'b0;
    d0 = rsp_dout; i0 = rsp_id; c0 = op_count;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      #1;
      checks++; if (req_ready !== '0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", k, req_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_dout !== d0 || rsp_id !== i0) begin failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d exp=1/%h/%0d", k, rsp_valid, rsp_dout, rsp_id, d0, i0); end
      checks++; if (op_count !== c0) begin failures++; $display("FAIL bp_count cyc=%0d got=%0d exp=%0d", k, op_count, c0); end
    end
    rsp_ready = 1'b1; req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_extremes();
    req_valid = 4'b0001; rsp_ready = 1'b1; rand_data();
    req_din0[W0-1:0] = 16'h8000; req_din1[W1-1:0] = 8'h80;
    tick();
    checks++; if (rsp_dout !== 24'h400000 || rsp_id !== 2'd0) begin failures++; $display("FAIL ext_minmin got=%h/%0d exp=400000/0", rsp_dout, rsp_id); end
    rand_data();
    req_din0[W0-1:0] = 16'h7FFF; req_din1[W1-1:0] = 8'h80;
    tick();
    checks++; if (rsp_dout !== 24'hC00080) begin failures++; $display("FAIL ext_maxmin got=%h exp=c00080", rsp_dout); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      #1;
      checks++; if (req_ready !== exp_ready()) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", k, req_ready, exp_ready()); end
      tick();
      checks++;
      if (rsp_valid !== m_valid || rsp_dout !== m_dout || rsp_id !== 2'(m_id) || op_count !== m_cnt) begin
        failures++;
        $display("FAIL rnd_rsp cyc=%0d got=%b/%h/%0d/%0d exp=%b/%h/%0d/%0d", k, rsp_valid, rsp_dout, rsp_id, op_count, m_valid, m_dout, m_id, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    req_valid = '1; rsp_ready = 1'b1;
    repeat (3) begin rand_data(); tick(); end
    ap_rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (rsp_valid !== 1'b0 || op_count !== 32'd0) begin failures++; $display("FAIL midrst_clear got=%b/%0d exp=0/0", rsp_valid, op_count); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    req_valid = 4'b1110; rand_data();
    tick();
    checks++; if (rsp_id !== 2'd1 || op_count !== 32'd1) begin failures++; $display("FAIL midrst_first got=%0d/%0d exp=1/1", rsp_id, op_count); end
    checks++; if (rsp_dout !== m_dout) begin failures++; $display("FAIL midrst_dout got=%h exp=%h", rsp_dout, m_dout); end
  endtask

  task automatic test_wrap();
    req_valid = '0; rsp_ready = 1'b1;
    tick();
    force dut.op_count = 32'hFFFFFFFF;
    #1;
    release dut.op_count;
    m_cnt = 32'hFFFFFFFF;
    #1;
    checks++; if (op_count !== 32'hFFFFFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffffffff", op_count); end
    req_valid = 4'b0010; rand_data();
    tick();
    checks++; if (op_count !== 32'd0) begin failures++; $display("FAIL wrap_count got=%h exp=0", op_count); end
    req_valid = '0;
    tick();
    checks++; if (op_count !== 32'd0) begin failures++; $display("FAIL wrap_idle got=%h exp=0", op_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_extremes();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
